// File: rtl/uart_pkg.sv
// Shared types for the UART debug-transport frame parser.
//   cmd_e   : command field carried in the frame header (bits [7:5])
//   err_e   : code reported on ERR_CODE_O while ERR_O pulses
//   state_e : parser FSM state, also exported on the debug port
package uart_pkg;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESET = 3'd3
  } cmd_e;

  typedef enum logic [1:0] {
    BAD_CMD  = 2'd0,
    BAD_ADDR = 2'd1,
    RESYNC   = 2'd2,
    TIMEOUT  = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PAY_ESC = 3'd3,
    S_ISSUE   = 3'd4
  } state_e;

endpackage

// File: rtl/dtm_uart_frame_parser_if.sv
// Byte-stream and request bundle of the frame parser.
//   slave  : parser side (consumes RX bytes, produces requests and errors)
//   master : environment side (UART receiver, channel logic)
// Handshake: a transfer happens on a rising clock edge where both valid and
// ready are high; a valid source holds its data stable until that edge, and
// valid never depends combinationally on ready.
interface dtm_uart_frame_parser_if #(
  parameter int DATA_W = 41
) ();
  logic              RX_VALID_I;
  logic [7:0]        RX_DATA_I;
  logic              RX_READY_O;
  logic              REQ_VALID_O;
  logic              REQ_READY_I;
  logic [2:0]        REQ_CMD_O;
  logic [4:0]        REQ_CH_O;
  logic [DATA_W-1:0] REQ_DATA_O;
  logic              ERR_O;
  logic [1:0]        ERR_CODE_O;

  modport slave (
    input  RX_VALID_I, RX_DATA_I, REQ_READY_I,
    output RX_READY_O, REQ_VALID_O, REQ_CMD_O, REQ_CH_O, REQ_DATA_O,
           ERR_O, ERR_CODE_O
  );

  modport master (
    output RX_VALID_I, RX_DATA_I, REQ_READY_I,
    input  RX_READY_O, REQ_VALID_O, REQ_CMD_O, REQ_CH_O, REQ_DATA_O,
           ERR_O, ERR_CODE_O
  );
endinterface

// File: rtl/dtm_uart_idle_timer.sv
// Inter-byte idle counter for the frame parser (built only when
// DTM_UART_TIMEOUT_EN is defined).
//   clk_i, rst_ni : clock, synchronous active-low reset
//   run_i         : parser is inside a frame; counter is held at 0 otherwise
//   clr_i         : a byte transferred this cycle; restart counting
//   expire_o      : counter has reached TIMEOUT_CYCLES while running
module dtm_uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clr_i,
  output logic expire_o
);
  localparam int              CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by run_i so the saturated value cannot re-fire after leaving a frame.
  assign expire_o = run_i && (cnt_q == LIMIT);
endmodule

// File: rtl/dtm_uart_frame_parser.sv
// Escape-framed command parser for the UART debug transport.
// Frame: ESC, header {cmd[7:5], addr[4:0]}, then NBYTES payload bytes (LSB
// first) for WRITE/RESET. ESC inside a payload is sent as ESC ESC; ESC
// followed by anything else abandons the frame and treats that byte as a new
// header. One request per frame is presented on the REQ_* handshake.
// Ports:
//   CLK_I, RST_NI : clock, synchronous active-low reset
//   bus           : RX byte stream in, request/error out (slave modport)
//   dbg_state_o   : current FSM state
// Optional feature: DTM_UART_TIMEOUT_EN adds an inter-byte timeout (error 3).
module dtm_uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] ESC            = 8'hB1,
  parameter int         NUM_CH         = 2,
  parameter int         DATA_W         = 41,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic                    CLK_I,
  input  logic                    RST_NI,
  dtm_uart_frame_parser_if.slave  bus,
  output state_e                  dbg_state_o
);
  localparam int         NBYTES = (DATA_W + 7) / 8;
  localparam logic [3:0] K_LAST = 4'(NBYTES - 1);

  if (NUM_CH < 1 || NUM_CH > 32 || DATA_W < 1 || DATA_W > 64 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("dtm_uart_frame_parser: parameter out of range");
  end

  state_e            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [DATA_W-1:0] data_q, data_d;
  cmd_e              cmd_q, cmd_d;
  logic [4:0]        ch_q, ch_d;
  logic              err_q, err_d;
  err_e              err_code_q, err_code_d;
  logic              rx_ready_q, rx_ready_d;
  logic              req_valid_q, req_valid_d;

  logic rx_fire, is_esc, decode, resync, store, expire;
  cmd_e hdr_cmd;
  logic hdr_cmd_ok, hdr_addr_ok;

  assign rx_fire     = bus.RX_VALID_I && rx_ready_q;
  assign is_esc      = (bus.RX_DATA_I == ESC);
  assign hdr_cmd     = cmd_e'(bus.RX_DATA_I[7:5]);
  assign hdr_cmd_ok  = hdr_cmd inside {READ, WRITE, RESET};
  assign hdr_addr_ok = int'(bus.RX_DATA_I[4:0]) < NUM_CH;

`ifdef DTM_UART_TIMEOUT_EN
  dtm_uart_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk_i    (CLK_I),
    .rst_ni   (RST_NI),
    .run_i    (state_q inside {S_HDR, S_PAYLOAD, S_PAY_ESC}),
    .clr_i    (rx_fire),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    data_d     = data_q;
    cmd_d      = cmd_q;
    ch_d       = ch_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    decode     = 1'b0;
    resync     = 1'b0;
    store      = 1'b0;

    unique case (state_q)
      S_IDLE:    if (rx_fire && is_esc) state_d = S_HDR;
      S_HDR:     if (rx_fire && !is_esc) decode = 1'b1;
      S_PAYLOAD: begin
        if (rx_fire) begin
          if (is_esc) state_d = S_PAY_ESC;
          else        store   = 1'b1;
        end
      end
      S_PAY_ESC: begin
        if (rx_fire) begin
          if (is_esc) begin
            store   = 1'b1;
            state_d = S_PAYLOAD;
          end else begin
            resync = 1'b1;
            decode = 1'b1;
          end
        end
      end
      S_ISSUE:   if (bus.REQ_READY_I) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Header decode, shared by HDR and the resync path. A resync already
    // reports code 2, so a bad resync header only drops back to IDLE.
    if (decode) begin
      state_d = S_IDLE;
      if (resync) begin
        err_d      = 1'b1;
        err_code_d = RESYNC;
      end
      if (!hdr_cmd_ok) begin
        if (!resync) begin
          err_d      = 1'b1;
          err_code_d = BAD_CMD;
        end
      end else if (!hdr_addr_ok) begin
        if (!resync) begin
          err_d      = 1'b1;
          err_code_d = BAD_ADDR;
        end
      end else begin
        cmd_d   = hdr_cmd;
        ch_d    = bus.RX_DATA_I[4:0];
        data_d  = '0;
        k_d     = '0;
        state_d = (hdr_cmd == READ) ? S_ISSUE : S_PAYLOAD;
      end
    end

    // Payload byte k lands in bits [8k +: 8]; bits at DATA_W and up drop out.
    if (store) begin
      for (int i = 0; i < DATA_W; i++) begin
        if ((i / 8) == int'(k_q)) data_d[i] = bus.RX_DATA_I[i % 8];
      end
      if (k_q == K_LAST) state_d = S_ISSUE;
      else               k_d     = k_q + 4'd1;
    end

    // A byte arriving on the expiry cycle counts as activity and wins.
    if (!rx_fire && expire) begin
      state_d    = S_IDLE;
      err_d      = 1'b1;
      err_code_d = TIMEOUT;
    end

    rx_ready_d  = (state_d != S_ISSUE);
    req_valid_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      data_q      <= '0;
      cmd_q       <= NOP;
      ch_q        <= '0;
      err_q       <= 1'b0;
      err_code_q  <= BAD_CMD;
      rx_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      data_q      <= data_d;
      cmd_q       <= cmd_d;
      ch_q        <= ch_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      rx_ready_q  <= rx_ready_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign bus.RX_READY_O  = rx_ready_q;
  assign bus.REQ_VALID_O = req_valid_q;
  assign bus.REQ_CMD_O   = cmd_q;
  assign bus.REQ_CH_O    = ch_q;
  assign bus.REQ_DATA_O  = data_q;
  assign bus.ERR_O       = err_q;
  assign bus.ERR_CODE_O  = err_code_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_dtm_uart_frame_parser.sv
// Testbench for dtm_uart_frame_parser: directed frames followed by random
// byte streams with random request backpressure, all checked cycle by cycle
// against a byte-stream reference model held in this file.
module tb_dtm_uart_frame_parser;
  import uart_pkg::*;

  localparam logic [7:0] ESC    = 8'hB1;
  localparam int         NUM_CH = 2;
  localparam int         DATA_W = 41;
  localparam int         NBYTES = (DATA_W + 7) / 8;
  localparam int         TO     = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dtm_uart_frame_parser_if #(.DATA_W(DATA_W)) u_if ();
  state_e dbg_state;

  dtm_uart_frame_parser #(
    .ESC(ESC), .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK_I       (clk),
    .RST_NI      (rst_n),
    .bus         (u_if),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [71:0] exp_q[$];          // {cmd[2:0], ch[4:0], data[63:0]}
  bit          exp_err = 1'b0;
  logic [1:0]  exp_err_code = 2'd0;

  logic [2:0]  seen_cmd;
  logic [4:0]  seen_ch;
  logic [63:0] seen_data;
  logic [1:0]  seen_err_code;
  int          seen_req_n, seen_err_n;
  bit          bp_en = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Hunting / awaiting header / collecting payload, with a pending-escape flag
  // and the un-escaped payload bytes kept in a queue.
  int         m_phase = 0;
  bit         m_esc = 1'b0;
  logic [7:0] m_pay[$];
  logic [2:0] m_cmd;
  logic [4:0] m_ch;
  int         m_idle = 0;

  task automatic model_reset();
    exp_q.delete();
    m_pay.delete();
    m_phase = 0;
    m_esc   = 1'b0;
    m_idle  = 0;
    exp_err = 1'b0;
  endtask

  task automatic raise_err(input logic [1:0] code);
    exp_err      = 1'b1;
    exp_err_code = code;
  endtask

  task automatic model_hdr(input logic [7:0] b, input bit resync);
    logic [2:0] c;
    c = b[7:5];
    if (resync) raise_err(2'd2);
    m_phase = 0;
    m_esc   = 1'b0;
    if (c < 3'd1 || c > 3'd3) begin
      if (!resync) raise_err(2'd0);
    end else if (int'(b[4:0]) >= NUM_CH) begin
      if (!resync) raise_err(2'd1);
    end else if (c == 3'd1) begin
      exp_q.push_back({c, b[4:0], 64'd0});
    end else begin
      m_cmd = c;
      m_ch  = b[4:0];
      m_pay.delete();
      m_phase = 2;
    end
  endtask

  task automatic pay_push(input logic [7:0] b);
    logic [63:0] d;
    m_pay.push_back(b);
    if (m_pay.size() == NBYTES) begin
      d = 64'd0;
      foreach (m_pay[i]) d = d | (64'(m_pay[i]) << (8 * i));
      d = d & ((64'd1 << DATA_W) - 64'd1);
      exp_q.push_back({m_cmd, m_ch, d});
      m_phase = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_phase == 0) begin
      if (b == ESC) m_phase = 1;
    end else if (m_phase == 1) begin
      if (b != ESC) model_hdr(b, 1'b0);
    end else if (m_esc) begin
      m_esc = 1'b0;
      if (b == ESC) pay_push(b);
      else          model_hdr(b, 1'b1);
    end else if (b == ESC) begin
      m_esc = 1'b1;
    end else begin
      pay_push(b);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: check outputs produced by the last edge, drive inputs for the
  // next edge, and advance the model to what that edge must do.
  task automatic cycle(input bit vld, input logic [7:0] b, input bit rdy,
                       input bit rstn, output bit acc);
    logic [71:0] e;
    bit in_frame;
    @(negedge clk);
    check_eq("err", u_if.ERR_O, exp_err);
    if (exp_err) check_eq("err_code", u_if.ERR_CODE_O, exp_err_code);
    check_eq("req_valid", u_if.REQ_VALID_O, exp_q.size() != 0);
    check_eq("rx_ready", u_if.RX_READY_O, exp_q.size() == 0);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check_eq("req_cmd", u_if.REQ_CMD_O, e[71:69]);
      check_eq("req_ch", u_if.REQ_CH_O, e[68:64]);
      check_eq("req_data", u_if.REQ_DATA_O, e[63:0]);
    end
    if (u_if.REQ_VALID_O) begin
      seen_cmd  = u_if.REQ_CMD_O;
      seen_ch   = u_if.REQ_CH_O;
      seen_data = 64'(u_if.REQ_DATA_O);
    end
    if (u_if.ERR_O) begin
      seen_err_code = u_if.ERR_CODE_O;
      seen_err_n++;
    end

    u_if.RX_VALID_I  = vld;
    u_if.RX_DATA_I   = b;
    u_if.REQ_READY_I = rdy;
    rst_n            = rstn;
    if (u_if.REQ_VALID_O && rdy && rstn) seen_req_n++;

    acc      = 1'b0;
    exp_err  = 1'b0;
    in_frame = (m_phase != 0);
    if (!rstn) begin
      model_reset();
    end else if (exp_q.size() != 0) begin
      if (rdy) void'(exp_q.pop_front());
    end else begin
      if (vld) begin
        acc = 1'b1;
        model_byte(b);
      end
`ifdef DTM_UART_TIMEOUT_EN
      if (vld || !in_frame) begin
        m_idle = 0;
      end else if (m_idle == TO) begin
        raise_err(2'd3);
        m_phase = 0;
        m_esc   = 1'b0;
        m_idle  = 0;
      end else begin
        m_idle++;
      end
`endif
    end
  endtask

  function automatic bit rand_rdy();
    return bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int tries;
    tries = 0;
    do begin
      cycle(1'b1, b, rand_rdy(), 1'b1, acc);
      tries++;
    end while (!acc && tries < 64);
    check_eq("send_accept", acc, 1'b1);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom_range(0, 255)), rand_rdy(), 1'b1, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      idle(1);
      n++;
    end
    idle(2);
  endtask

  task automatic clear_seen();
    seen_req_n    = 0;
    seen_err_n    = 0;
    seen_cmd      = 3'd7;
    seen_ch       = 5'd31;
    seen_data     = '1;
    seen_err_code = 2'd0;
  endtask

  task automatic send_payload_byte(input logic [7:0] b);
    send_byte(b);
    if (b == ESC) send_byte(ESC);
  endtask

  task automatic random_frame();
    int kind;
    logic [7:0] b;
    kind = $urandom_range(0, 9);
    if (kind == 0) begin
      repeat ($urandom_range(1, 3)) send_byte(8'($urandom_range(0, 255)));
    end else if (kind == 1) begin
      send_byte(ESC);
      b = {($urandom_range(0, 1) != 0) ? 3'($urandom_range(4, 7)) : 3'd0, 5'($urandom_range(0, 31))};
      send_byte(b);
    end else if (kind == 2) begin
      send_byte(ESC);
      send_byte({3'($urandom_range(1, 3)), 5'($urandom_range(NUM_CH, 31))});
    end else if (kind == 3) begin
      send_byte(ESC);
      send_byte({3'd2, 5'($urandom_range(0, NUM_CH - 1))});
      repeat ($urandom_range(1, NBYTES - 1)) begin
        b = 8'($urandom_range(0, 255));
        if (b == ESC) b = 8'h12;
        send_byte(b);
      end
      send_byte(ESC);
      send_byte({3'($urandom_range(0, 7)), 5'($urandom_range(0, 3))});
    end else begin
      send_byte(ESC);
      if ($urandom_range(0, 7) == 0) send_byte(ESC);
      b = {3'($urandom_range(1, 3)), 5'($urandom_range(0, NUM_CH - 1))};
      send_byte(b);
      if (b[7:5] != 3'd1) begin
        for (int i = 0; i < NBYTES; i++) begin
          send_payload_byte(($urandom_range(0, 3) == 0) ? ESC : 8'($urandom_range(0, 255)));
        end
      end
    end
    idle($urandom_range(0, 3));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    u_if.RX_VALID_I  = 1'b0;
    u_if.RX_DATA_I   = 8'h00;
    u_if.REQ_READY_I = 1'b1;
    rst_n            = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rx_ready", u_if.RX_READY_O, 1'b1);
    check_eq("rst_req_valid", u_if.REQ_VALID_O, 1'b0);
    check_eq("rst_cmd", u_if.REQ_CMD_O, 3'd0);
    check_eq("rst_ch", u_if.REQ_CH_O, 5'd0);
    check_eq("rst_data", u_if.REQ_DATA_O, 64'd0);
    check_eq("rst_err", u_if.ERR_O, 1'b0);
    check_eq("rst_err_code", u_if.ERR_CODE_O, 2'd0);
    check_eq("rst_state", dbg_state, S_IDLE);
    model_reset();
    idle(2);

    // Write
    clear_seen();
    send_seq('{8'hB1, 8'h41, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'hFC});
    drain();
    check_eq("wr_cmd", seen_cmd, 3'd2);
    check_eq("wr_ch", seen_ch, 5'd1);
    check_eq("wr_data", seen_data, 64'h040_0000_0001);
    check_eq("wr_nreq", seen_req_n, 1);
    check_eq("wr_nerr", seen_err_n, 0);

    // Read with stray bytes in front
    clear_seen();
    send_seq('{8'h55, 8'hAA, 8'hB1, 8'h20});
    drain();
    check_eq("rd_cmd", seen_cmd, 3'd1);
    check_eq("rd_ch", seen_ch, 5'd0);
    check_eq("rd_data", seen_data, 64'd0);
    check_eq("rd_nreq", seen_req_n, 1);

    // Literal escape in payload
    clear_seen();
    send_seq('{8'hB1, 8'h40, 8'hB1, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    drain();
    check_eq("lit_cmd", seen_cmd, 3'd2);
    check_eq("lit_data", seen_data, 64'h0B1);

    // Resync
    clear_seen();
    send_seq('{8'hB1, 8'h40, 8'h11, 8'h22, 8'hB1, 8'h21});
    drain();
    check_eq("rsy_err_code", seen_err_code, 2'd2);
    check_eq("rsy_nerr", seen_err_n, 1);
    check_eq("rsy_nreq", seen_req_n, 1);
    check_eq("rsy_cmd", seen_cmd, 3'd1);
    check_eq("rsy_ch", seen_ch, 5'd1);

    // Bad address, bad command
    clear_seen();
    send_seq('{8'hB1, 8'h45});
    idle(3);
    check_eq("badaddr_code", seen_err_code, 2'd1);
    check_eq("badaddr_nreq", seen_req_n, 0);
    clear_seen();
    send_seq('{8'hB1, 8'hE0});
    idle(3);
    check_eq("badcmd_code", seen_err_code, 2'd0);
    check_eq("badcmd_nerr", seen_err_n, 1);
    check_eq("badcmd_nreq", seen_req_n, 0);

    // Backpressure on a READ
    clear_seen();
    send_seq('{8'hB1, 8'h21});
    repeat (5) cycle(1'b0, 8'hB1, 1'b0, 1'b1, acc);
    drain();
    check_eq("bp_nreq", seen_req_n, 1);
    check_eq("bp_ch", seen_ch, 5'd1);

    // Reset mid-frame
    clear_seen();
    send_seq('{8'hB1, 8'h40, 8'h11});
    cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    idle(4);
    check_eq("rstmid_nreq", seen_req_n, 0);
    check_eq("rstmid_nerr", seen_err_n, 0);

`ifdef DTM_UART_TIMEOUT_EN
    clear_seen();
    send_seq('{8'hB1, 8'h40, 8'h11});
    idle(TO + 3);
    check_eq("to_code", seen_err_code, 2'd3);
    check_eq("to_nerr", seen_err_n, 1);
    check_eq("to_nreq", seen_req_n, 0);
`endif

    // Random streams with backpressure
    bp_en = 1'b1;
    for (int f = 0; f < 300; f++) random_frame();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dtm_uart_frame_parser.md
# dtm_uart_frame_parser

Byte-level frame parser for the UART debug transport. It sits between the UART receiver's byte stream and the DMI/strobe channel logic. It finds escape-framed commands, un-escapes payload bytes and assembles a payload of `DATA_W` bits. It then issues one request per frame to one of `NUM_CH` addressed channels. It generalises the fixed DMI-only command decode to any channel count and payload width, and adds literal-escape handling, resync and error reporting.

## Interface
- `ESC`, 8'hB1, frame-start / escape byte
- `NUM_CH`, 2, number of addressable channels (1..32); valid addresses are 0..NUM_CH-1
- `DATA_W`, 41, payload width in bits (1..64); `NBYTES = (DATA_W+7)/8`
- `TIMEOUT_CYCLES`, 4096, inter-byte timeout (used only with the macro)

Ports:
- `CLK_I`  in  1  clock
- `RST_NI`  in  1  reset; one clock; reset is synchronous and active-low
- `RX_VALID_I`  in  1  received byte valid
- `RX_DATA_I`  in  8  received byte
- `RX_READY_O`  out  1  parser accepts a byte
- `REQ_VALID_O`  out  1  request valid
- `REQ_READY_I`  in  1  request accepted
- `REQ_CMD_O`  out  3  command (`cmd_e`)
- `REQ_CH_O`  out  5  channel address
- `REQ_DATA_O`  out  DATA_W  payload; zero for READ
- `ERR_O`  out  1  one-cycle error pulse
- `ERR_CODE_O`  out  2  error code; valid while `ERR_O` is high

## Operation
- Frame format: `ESC`, then header `{cmd[7:5], addr[4:0]}`, then `NBYTES` payload bytes, least significant byte first.
  - Payload bits at position `DATA_W` and above in the last byte are discarded.
  - READ frames have no payload. WRITE and RESET frames carry a payload.
- Byte transfer: a byte moves when `RX_VALID_I && RX_READY_O`. `RX_READY_O` = 1 in every state except ISSUE.
- States:
  - IDLE: `ESC` → HDR. Any other byte is dropped silently.
  - HDR: `ESC` → stay in HDR. Otherwise decode the header:
    - cmd not READ/WRITE/RESET → ERR code 0, go to IDLE.
    - addr ≥ NUM_CH → ERR code 1, go to IDLE.
    - READ → ISSUE.
    - WRITE/RESET → PAYLOAD with byte index k = 0; the payload register is cleared.
  - PAYLOAD: a non-`ESC` byte is stored at `data[8k +: 8]` and k increments. `ESC` → PAY_ESC.
  - PAY_ESC: `ESC` → store a literal `ESC` byte and return to PAYLOAD. Any other byte → ERR code 2 (resync); that byte is decoded as a new header, exactly as in HDR.
  - After the byte with k = NBYTES-1 is stored → ISSUE.
  - ISSUE: `REQ_VALID_O` = 1 with cmd, ch and data held stable. On `REQ_READY_I` → IDLE.
- Priority: `RST_NI` low overrides everything. In a single cycle, the error pulse and a new header decode may both occur; the request is issued on a later cycle.

## Timing
- Reset values: `RX_READY_O` = 1, `REQ_VALID_O` = 0, `REQ_CMD_O` = 0, `REQ_CH_O` = 0, `REQ_DATA_O` = 0, `ERR_O` = 0, `ERR_CODE_O` = 0. The state is IDLE and k = 0.
- All outputs are registered.
- `REQ_VALID_O` rises on the cycle after the final byte transfer: the last payload byte, or the header for READ.
- `REQ_VALID_O` falls and `RX_READY_O` rises on the cycle after the `REQ_READY_I` handshake. There is no combinational path from ready to valid.
- `ERR_O` is high for exactly one cycle, on the cycle after the offending byte transfer.
- Reset asserted mid-frame discards the partial frame. No request and no error are produced.

## Configuration
- `DTM_UART_TIMEOUT_EN` defined:
  - An idle counter runs in HDR, PAYLOAD and PAY_ESC. It clears on every byte transfer.
  - When it reaches `TIMEOUT_CYCLES` → ERR code 3, go to IDLE.
  - The counter is held at 0 in IDLE and ISSUE.
- Not defined: no counter and no code 3; partial frames wait indefinitely.

## Structure
- `uart_pkg` holds:
  - `cmd_e`: NOP = 3'd0, READ = 3'd1, WRITE = 3'd2, RESET = 3'd3.
  - `err_e`: BAD_CMD = 0, BAD_ADDR = 1, RESYNC = 2, TIMEOUT = 3.
  - The state enum.
- Sub-module `dtm_uart_idle_timer` (counter plus clear/expire logic) is instantiated only under `DTM_UART_TIMEOUT_EN`.

## Test plan
All scenarios use defaults (ESC = B1, NUM_CH = 2, DATA_W = 41), `REQ_READY_I` = 1 unless stated.
- Write: B1 41 01 00 00 00 40 FC → one request with CMD = WRITE, CH = 1, DATA = 41'h040_0000_0001, one cycle after the last byte; no error.
- Read: B1 20 → CMD = READ, CH = 0, DATA = 0. Stray bytes 55 AA sent before the B1 are ignored.
- Literal escape: B1 40 B1 B1 00 00 00 00 00 → CMD = WRITE, CH = 0, DATA = 41'h0B1.
- Resync: B1 40 11 22 B1 21 → ERR code 2 pulse, then CMD = READ, CH = 1, DATA = 0. The partial payload is never issued.
- Errors: B1 45 → ERR code 1, no request. B1 E0 → ERR code 0, no request.
- Backpressure, reset and timeout:
  - Hold `REQ_READY_I` = 0 for 5 cycles during a READ → `REQ_VALID_O` and outputs stay stable and `RX_READY_O` = 0; the request completes when ready rises.
  - Reset after B1 40 11 → no request and no error.
  - With the macro: B1 40 11, then idle for `TIMEOUT_CYCLES` cycles → ERR code 3 and return to IDLE.
